// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the iterative RV32M
//               multiply/divide execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // rs1 is treated as signed for these ops
  function automatic logic op_a_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_b_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide share one 64-bit accumulator and a 5-bit
//               iteration counter; fixed 33-edge latency, start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mb_q, mb_d;
  logic [XLEN-1:0]     a_q, a_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;       // product / quotient sign
  logic                rem_neg_q, rem_neg_d;
  logic                bzero_q, bzero_d;
  logic [4:0]          rd_pend_q, rd_pend_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic                done_q, done_d;

  // Operand decode at issue time
  op_e             op_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] ma_in, mb_in;

  assign op_in    = op_e'(op);
  assign a_neg_in = op_a_signed(op_in) && a[XLEN-1];
  assign b_neg_in = op_b_signed(op_in) && b[XLEN-1];
  assign ma_in    = a_neg_in ? -a : a;
  assign mb_in    = b_neg_in ? -b : b;

  // One shift-add multiply step: conditionally add multiplicand to the high
  // half, then shift the whole accumulator right by one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: high half is the partial remainder, low half
  // shifts dividend bits out and quotient bits in.
  logic [XLEN:0]     div_rem, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_rem - {1'b0, mb_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                           : {div_rem[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};

  // Sign fix-up applied in FIN
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mb_q      <= '0;
      a_q       <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mb_q      <= mb_d;
      a_q       <= a_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      rd_pend_q <= rd_pend_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mb_d      = mb_q;
    a_d       = a_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    rd_pend_d = rd_pend_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // kill in the same cycle suppresses the request
        if (start && !kill) begin
          op_d      = op_in;
          acc_d     = {{XLEN{1'b0}}, ma_in};
          mb_d      = mb_in;
          a_d       = a;
          neg_d     = a_neg_in ^ b_neg_in;
          rem_neg_d = a_neg_in;
          bzero_d   = (b == '0);
          rd_pend_d = rd_in;
          count_d   = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (kill) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          acc_d   = op_q[2] ? div_next : mul_next;
          count_d = count_q + 1'b1;  // wraps to 0 after the last iteration
          if (count_q == CNT_W'(ITER - 1)) begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        if (!kill) begin
          done_d   = 1'b1;
          rd_out_d = rd_pend_q;
          case (op_q)
            OP_MUL:                       result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_d = bzero_q ? {XLEN{1'b1}} : quo_fix;
            OP_REM, OP_REMU:              result_d = bzero_q ? a_q : rem_fix;
            default:                      result_d = result_q;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] C_MUL    = 3'b000;
  localparam logic [2:0] C_MULH   = 3'b001;
  localparam logic [2:0] C_MULHSU = 3'b010;
  localparam logic [2:0] C_MULHU  = 3'b011;
  localparam logic [2:0] C_DIV    = 3'b100;
  localparam logic [2:0] C_DIVU   = 3'b101;
  localparam logic [2:0] C_REM    = 3'b110;
  localparam logic [2:0] C_REMU   = 3'b111;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks;
  int n_pass;
  int cyc;
  int t0;
  int lat;
  int done_seen;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one request for one cycle; t0 marks the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] rd);
    @(negedge clk);
    op = o; a = x; b = y; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Wait (bounded) for done; returns in the done cycle, #1 after its edge.
  task automatic wait_done();
    lat = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [4:0] rd, input logic [31:0] exp);
    issue(o, x, y, rd);
    wait_done();
    check({tag, ".lat"},    32'(lat),    32'd33);
    check({tag, ".result"}, result,      exp);
    check({tag, ".rd"},     32'(rd_out), 32'(rd));
    check({tag, ".busy"},   32'(busy),   32'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; t0 = 0; lat = 0; done_seen = 0;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0; rd_in = '0;

    #12;
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    check("reset.result", result,      32'd0);
    check("reset.rd",     32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Multiply variants
    run("mul",    C_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run("mulh",   C_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6, 32'h4000_0000);
    run("mulhu",  C_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
    run("mulhsu", C_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8, 32'hFFFF_FFFF);

    // Divide variants including signed overflow
    run("div",     C_DIV, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    run("rem",     C_REM, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    run("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    run("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000);

    // Divide by zero
    run("divu_z", C_DIVU, 32'd5,         32'd0, 5'd13, 32'hFFFF_FFFF);
    run("remu_z", C_REMU, 32'd5,         32'd0, 5'd14, 32'd5);
    run("div_z",  C_DIV,  32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFFF);
    run("rem_z",  C_REM,  32'hFFFF_FFF9, 32'd0, 5'd16, 32'hFFFF_FFF9);

    // start while busy is ignored
    issue(C_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd17);
    check("done_pulse_width", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("busy_mid", 32'(busy), 32'd1);
    op = C_MUL; a = 32'd2; b = 32'd3; rd_in = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("busy_ign.lat",    32'(lat),    32'd33);
    check("busy_ign.result", result,      32'd1);
    check("busy_ign.rd",     32'(rd_out), 32'd17);

    // Back-to-back: request presented during the done cycle
    run("b2b", C_REMU, 32'd100, 32'd7, 5'd18, 32'd2);

    // kill sampled at edge 10 of a DIV
    issue(C_DIV, 32'd100, 32'd7, 5'd19);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill.busy",   32'(busy),   32'd0);
    check("kill.done",   32'(done),   32'd0);
    check("kill.result", result,      32'd2);
    check("kill.rd",     32'(rd_out), 32'd18);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = done_seen + 1;
    end
    check("kill.no_done", 32'(done_seen), 32'd0);

    // kill and start together in IDLE: start dropped
    @(negedge clk);
    op = C_MUL; a = 32'd5; b = 32'd5; rd_in = 5'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start.busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN
    issue(C_MUL, 32'd9, 32'd9, 5'd3);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst.busy",   32'(busy),   32'd0);
    check("arst.done",   32'(done),   32'd0);
    check("arst.result", result,      32'd0);
    check("arst.rd",     32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", C_MUL, 32'd3, 32'd4, 5'd20, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Consumes the two register-file read operands (rs1, rs2) and the destination index, and produces a 32-bit result plus destination tag for the writeback stage, which drives the register-file write port.
- Fixed-latency, one operation in flight, start/done handshake; the pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only when busy=0.
op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a  in  32  rs1 operand.
b  in  32  rs2 operand.
rd_in  in  5  destination register index.
kill  in  1  abort the in-flight operation (pipeline flush).
busy  out  1  operation in progress.
done  out  1  one-cycle pulse: result and rd_out are valid.
result  out  32  result, held until the next accepted start.
rd_out  out  5  destination index captured at start, held with result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, result=0, rd_out=0; all internal registers cleared.
- States:
  - IDLE: start=1 at edge E0 captures op, a, b and rd_in, then moves to RUN with count=0.
  - RUN: one iteration per edge for 32 edges (E1..E32); count increments and wraps 31->0 on leaving.
  - FIN: entered at E32. The sign fix-up and result register load occur at E33, which also returns the unit to IDLE.
  - done=1 for exactly the cycle following E33.
- busy=1 from the cycle after E0 through the cycle following E32; busy=0 in the done cycle.
- Total latency is 33 edges, independent of operands and divide-by-zero.
- Start handling:
  - start while busy=1 is ignored; no queueing.
  - start asserted in the done cycle is accepted normally (back-to-back issue).
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL/MULH signed×signed; MULHSU signed a × unsigned b; MULHU unsigned.
  - Shift-add into a 64-bit accumulator; negated at FIN if the sign flag is set.
  - MUL returns bits [31:0]; the other three ops return bits [63:32].
- Divide:
  - Restoring division on magnitudes (DIV/REM signed; DIVU/REMU unsigned).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Boundary cases:
  - b==0 (flag captured at E0): quotient=0xFFFFFFFF and remainder=a. This overrides sign fix-up for all four divide ops.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0. The natural datapath produces this; no special case required.
- kill:
  - With busy=1, kill forces IDLE at the next edge; no done, and result/rd_out are unchanged.
  - kill in IDLE has no effect.
  - kill and start in the same IDLE cycle: start is ignored.
- done never asserts without a preceding accepted start.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN;
  - the op_e enum with the funct3 encodings above;
  - the state_e enum {IDLE, RUN, FIN};
  - ITER = 32.
- No sub-module. The multiply and divide datapaths share the 64-bit accumulator and the counter inside a single module.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> done exactly 33 edges after start, result=0xFFFFFFEB, rd_out=rd_in.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF; REM 0xFFFFFFF9/0 -> 0xFFFFFFF9. Latency is still 33 edges.
- Start pulsed while busy, then start in the done cycle -> first pulse ignored; second operation completes 33 edges after the done cycle with the correct result.
- kill at edge 10 of a DIV -> busy=0 next cycle, no done, prior result held. Asynchronous reset mid-RUN -> all outputs 0 immediately, and a fresh MUL 3×4=12 completes correctly.
